// File: rtl/zbt_sram_ctrl_pkg.sv
// Shared widths, pipeline latency and requester tag ordinals for the ZBT SRAM bank controller.
// The arbiter uses the same one-hot tag encoding.
package zbt_sram_ctrl_pkg;

    localparam int unsigned ZBT_ADDR_W = 19;
    localparam int unsigned ZBT_DATA_W = 36;
    localparam int unsigned ZBT_TAG_W  = 4;
    localparam int unsigned ZBT_RD_LAT = 2;
    localparam int unsigned ZBT_BWE_W  = 4;

    typedef enum logic [ZBT_TAG_W-1:0] {
        TAG_NONE = 4'b0000,
        TAG_NTSC = 4'b0001,
        TAG_VGA  = 4'b0010,
        TAG_LPF  = 4'b0100,
        TAG_PT   = 4'b1000
    } zbt_tag_e;

    // All byte lanes enabled (active low) on a write address cycle, none otherwise.
    function automatic logic [ZBT_BWE_W-1:0] bwe_for(input logic is_write);
        return is_write ? '0 : '1;
    endfunction

endpackage

// File: rtl/zbt_sram_ctrl_if.sv
// Request/response handshake between the frame-buffer arbiter (master) and one ZBT bank
// controller (slave).
interface zbt_sram_ctrl_if
    import zbt_sram_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W = ZBT_ADDR_W,
    parameter int unsigned DATA_W = ZBT_DATA_W,
    parameter int unsigned TAG_W  = ZBT_TAG_W
);

    logic              req_valid;
    logic              req_ready;
    logic              req_wr;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic [TAG_W-1:0]  req_tag;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_data;
    logic [TAG_W-1:0]  rsp_tag;

    modport master (
        output req_valid, req_wr, req_addr, req_wdata, req_tag,
        input  req_ready, rsp_valid, rsp_data, rsp_tag
    );

    modport slave (
        input  req_valid, req_wr, req_addr, req_wdata, req_tag,
        output req_ready, rsp_valid, rsp_data, rsp_tag
    );

endinterface

// File: rtl/zbt_delay_pipe.sv
// Width/depth parameterised shift register with synchronous clear; every stage is exposed
// so the caller can tap any pipeline position.
module zbt_delay_pipe #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 3
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic [WIDTH-1:0]            din,
    output logic [DEPTH-1:0][WIDTH-1:0] taps
);

    always_ff @(posedge clock) begin
        if (reset) begin
            taps <= '0;
        end else begin
            taps[0] <= din;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                taps[i] <= taps[i-1];
            end
        end
    end

endmodule

// File: rtl/zbt_sram_ctrl.sv
// Pin-level sequencer for one pipelined ZBT SRAM bank: tagged requests in, in-order tagged
// read data out. Define ZBT_TURNAROUND_EN to insert a bus-turnaround bubble on read->write.
module zbt_sram_ctrl
    import zbt_sram_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W = ZBT_ADDR_W,
    parameter int unsigned DATA_W = ZBT_DATA_W,
    parameter int unsigned TAG_W  = ZBT_TAG_W,
    parameter int unsigned RD_LAT = ZBT_RD_LAT
) (
    input  logic                 clock,
    input  logic                 reset,
    zbt_sram_ctrl_if.slave       bus,
    output logic [ADDR_W-1:0]    ram_addr,
    inout  wire  [DATA_W-1:0]    ram_data,
    output logic                 ram_we_b,
    output logic                 ram_ce_b,
    output logic                 ram_cen_b,
    output logic                 ram_oe_b,
    output logic                 ram_adv_ld,
    output logic [ZBT_BWE_W-1:0] ram_bwe_b
);

    localparam int unsigned STAGE_W = 2 + TAG_W + DATA_W;
    localparam int unsigned DEPTH   = RD_LAT + 1;

    logic                          ready_q;
    logic                          accept;
    logic [STAGE_W-1:0]            stage_in;
    logic [DEPTH-1:0][STAGE_W-1:0] taps;
    logic                          pipe_unused;

    logic                          pre_valid;
    logic                          pre_wr;
    logic [DATA_W-1:0]             pre_wdata;
    logic                          last_valid;
    logic                          last_wr;
    logic [TAG_W-1:0]              last_tag;

    logic                          drive_en;
    logic [DATA_W-1:0]             wdata_q;
    logic                          rsp_valid_q;
    logic [DATA_W-1:0]             rsp_data_q;
    logic [TAG_W-1:0]              rsp_tag_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            ready_q <= 1'b0;
        end else begin
            ready_q <= 1'b1;
        end
    end

    assign accept = bus.req_valid && bus.req_ready;

`ifdef ZBT_TURNAROUND_EN
    logic rd_last_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            rd_last_q <= 1'b0;
        end else begin
            rd_last_q <= accept && !bus.req_wr;
        end
    end

    // A write right behind an accepted read is held off one cycle so the SRAM's read data
    // and our write data never occupy adjacent bus cycles.
    assign bus.req_ready = ready_q && !reset && !(rd_last_q && bus.req_valid && bus.req_wr);
`else
    assign bus.req_ready = ready_q && !reset;
`endif

    // Stage k of the pipe describes the request whose address went out k+1 cycles ago.
    assign stage_in = {accept, bus.req_wr, bus.req_tag, bus.req_wdata};

    zbt_delay_pipe #(
        .WIDTH(STAGE_W),
        .DEPTH(DEPTH)
    ) u_pipe (
        .clock(clock),
        .reset(reset),
        .din  (stage_in),
        .taps (taps)
    );

    assign pre_valid   = taps[RD_LAT-1][STAGE_W-1];
    assign pre_wr      = taps[RD_LAT-1][STAGE_W-2];
    assign pre_wdata   = taps[RD_LAT-1][DATA_W-1:0];
    assign last_valid  = taps[RD_LAT][STAGE_W-1];
    assign last_wr     = taps[RD_LAT][STAGE_W-2];
    assign last_tag    = taps[RD_LAT][DATA_W +: TAG_W];
    assign pipe_unused = ^taps;

    always_ff @(posedge clock) begin
        if (reset) begin
            ram_addr  <= '0;
            ram_we_b  <= 1'b1;
            ram_ce_b  <= 1'b1;
            ram_bwe_b <= '1;
            ram_cen_b <= 1'b1;
        end else begin
            if (accept) begin
                ram_addr <= bus.req_addr;
            end
            ram_ce_b  <= !accept;
            ram_we_b  <= !(accept && bus.req_wr);
            ram_bwe_b <= bwe_for(accept && bus.req_wr);
            ram_cen_b <= 1'b0;
        end
    end

    assign ram_adv_ld = 1'b0;

    // Bus direction is decided one stage early so both drive_en and oe_b come straight from flops.
    always_ff @(posedge clock) begin
        if (reset) begin
            drive_en <= 1'b0;
            wdata_q  <= '0;
            ram_oe_b <= 1'b1;
        end else begin
            drive_en <= pre_valid && pre_wr;
            wdata_q  <= pre_wdata;
            ram_oe_b <= !(pre_valid && !pre_wr);
        end
    end

    assign ram_data = drive_en ? wdata_q : 'z;

    always_ff @(posedge clock) begin
        if (reset) begin
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_tag_q   <= '0;
        end else begin
            rsp_valid_q <= last_valid && !last_wr;
            if (last_valid && !last_wr) begin
                rsp_data_q <= ram_data;
                rsp_tag_q  <= last_tag;
            end
        end
    end

    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_tag   = rsp_tag_q;

endmodule

// File: tb/tb_zbt_sram_ctrl.sv
// Directed and random bench for zbt_sram_ctrl against a pipelined ZBT SRAM model and an
// in-order read scoreboard.
module tb_zbt_sram_ctrl;
    import zbt_sram_ctrl_pkg::*;

`ifdef ZBT_TURNAROUND_EN
    localparam int EXP_STALL = 1;
`else
    localparam int EXP_STALL = 0;
`endif

    typedef struct {
        int          cyc;
        logic [35:0] data;
        logic [3:0]  tag;
    } rsp_rec_t;

    typedef struct {
        int          cyc;
        logic [35:0] data;
    } drv_rec_t;

    typedef struct {
        logic [35:0] data;
        logic [3:0]  tag;
    } exp_rec_t;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [18:0] ram_addr;
    wire  [35:0] ram_data;
    logic        ram_we_b, ram_ce_b, ram_cen_b, ram_oe_b, ram_adv_ld;
    logic [3:0]  ram_bwe_b;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int ce_cnt, we_cnt, oe_cnt, stall_cnt;
    int contention_cnt = 0;
    int bwe_bad_cnt;

    rsp_rec_t    rsp_q[$];
    drv_rec_t    drv_q[$];
    exp_rec_t    exp_q[$];
    logic [35:0] ref_mem [512];

    zbt_sram_ctrl_if bus ();

    zbt_sram_ctrl dut (
        .clock     (clock),
        .reset     (reset),
        .bus       (bus),
        .ram_addr  (ram_addr),
        .ram_data  (ram_data),
        .ram_we_b  (ram_we_b),
        .ram_ce_b  (ram_ce_b),
        .ram_cen_b (ram_cen_b),
        .ram_oe_b  (ram_oe_b),
        .ram_adv_ld(ram_adv_ld),
        .ram_bwe_b (ram_bwe_b)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // Behavioural pipelined ZBT SRAM: data two cycles after address, both directions.
    logic        m_v0, m_v1, m_w0, m_w1, m_drv;
    logic [8:0]  m_a0, m_a1;
    logic [35:0] m_q;
    logic [35:0] mem [512];

    always @(posedge clock) begin
        if (reset) begin
            m_v0  <= 1'b0;
            m_v1  <= 1'b0;
            m_w0  <= 1'b0;
            m_w1  <= 1'b0;
            m_drv <= 1'b0;
            m_a0  <= '0;
            m_a1  <= '0;
            m_q   <= '0;
            for (int i = 0; i < 512; i++) mem[i] <= '0;
        end else begin
            m_v0  <= !ram_ce_b;
            m_w0  <= !ram_we_b;
            m_a0  <= ram_addr[8:0];
            m_v1  <= m_v0;
            m_w1  <= m_w0;
            m_a1  <= m_a0;
            m_drv <= m_v0 && !m_w0;
            if (m_v1 && m_w1) mem[m_a1] <= ram_data;
            if (m_v1 && m_w1 && m_a1 == m_a0) m_q <= ram_data;
            else m_q <= mem[m_a0];
        end
    end

    assign ram_data = (m_drv && !ram_oe_b) ? m_q : 'z;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clear_log();
        rsp_q.delete();
        drv_q.delete();
        ce_cnt = 0;
        we_cnt = 0;
        oe_cnt = 0;
        stall_cnt = 0;
        bwe_bad_cnt = 0;
    endtask

    task automatic clear_ref();
        for (int i = 0; i < 512; i++) ref_mem[i] = '0;
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    // Called just after a rising edge; returns just after the edge that follows acceptance.
    task automatic issue(input logic wr, input logic [18:0] a, input logic [35:0] d,
                         input logic [3:0] t, output int acc);
        int n = 0;
        exp_rec_t e;
        bus.req_valid = 1'b1;
        bus.req_wr    = wr;
        bus.req_addr  = a;
        bus.req_wdata = d;
        bus.req_tag   = t;
        @(negedge clock);
        while (!bus.req_ready && n < 10) begin
            @(negedge clock);
            n++;
        end
        acc = cyc;
        if (!bus.req_ready) begin
            check("accept_timeout", 64'd0, 64'd1);
            acc = -1;
        end else if (wr) begin
            ref_mem[a[8:0]] = d;
        end else begin
            e.data = ref_mem[a[8:0]];
            e.tag  = t;
            exp_q.push_back(e);
        end
        @(posedge clock);
        #1;
        bus.req_valid = 1'b0;
    endtask

    // Cycle monitor and in-order scoreboard, sampled mid-cycle.
    initial begin
        exp_rec_t e;
        rsp_rec_t r;
        drv_rec_t dv;
        forever begin
            @(negedge clock);
            if (!reset && bus.req_valid && !bus.req_ready) stall_cnt++;
            if (!ram_ce_b) ce_cnt++;
            if (!ram_we_b) we_cnt++;
            if (!ram_oe_b) oe_cnt++;
            if (ram_bwe_b !== (ram_we_b ? 4'hF : 4'h0)) bwe_bad_cnt++;
            if (dut.drive_en && !ram_oe_b) contention_cnt++;
            if (dut.drive_en) begin
                dv.cyc  = cyc;
                dv.data = ram_data;
                drv_q.push_back(dv);
            end
            if (bus.rsp_valid) begin
                r.cyc  = cyc;
                r.data = bus.rsp_data;
                r.tag  = bus.rsp_tag;
                rsp_q.push_back(r);
                if (exp_q.size() == 0) begin
                    check("rsp_extra", 64'd1, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("rsp_data", r.data, e.data);
                    check("rsp_tag", r.tag, e.tag);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int a0, a1, a2, ar, aw, n_ops;
        logic        wr;
        logic [18:0] a;
        logic [35:0] d;
        logic [3:0]  t;

        bus.req_valid = 1'b0;
        bus.req_wr    = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.req_tag   = '0;
        clear_ref();
        clear_log();

        // Reset values
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("rst_ready", bus.req_ready, 1'b0);
        check("rst_rsp_valid", bus.rsp_valid, 1'b0);
        check("rst_rsp_data", bus.rsp_data, 36'd0);
        check("rst_rsp_tag", bus.rsp_tag, 4'd0);
        check("rst_ce_b", ram_ce_b, 1'b1);
        check("rst_we_b", ram_we_b, 1'b1);
        check("rst_oe_b", ram_oe_b, 1'b1);
        check("rst_bwe_b", ram_bwe_b, 4'hF);
        check("rst_addr", ram_addr, 19'd0);
        check("rst_drive", dut.drive_en, 1'b0);
        @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        check("ready_first_cycle", bus.req_ready, 1'b0);
        @(negedge clock);
        check("ready_second_cycle", bus.req_ready, 1'b1);
        check("adv_ld", ram_adv_ld, 1'b0);
        check("cen_b", ram_cen_b, 1'b0);
        step(1);

        // Write then read back one word
        clear_log();
        issue(1'b1, 19'h00123, 36'h5A5A5A5A5, TAG_NONE, aw);
        step(6);
        check("w1_drive_count", drv_q.size(), 1);
        if (drv_q.size() > 0) begin
            check("w1_drive_cycle", drv_q[0].cyc - aw, 3);
            check("w1_drive_data", drv_q[0].data, 36'h5A5A5A5A5);
        end
        check("w1_bwe", bwe_bad_cnt, 0);
        clear_log();
        issue(1'b0, 19'h00123, '0, TAG_LPF, ar);
        step(8);
        check("r1_rsp_count", rsp_q.size(), 1);
        if (rsp_q.size() > 0) begin
            check("r1_latency", rsp_q[0].cyc - ar, 4);
            check("r1_data", rsp_q[0].data, 36'h5A5A5A5A5);
            check("r1_tag", rsp_q[0].tag, 4'b0100);
        end

        // Three back-to-back reads
        clear_log();
        issue(1'b0, 19'h00010, '0, TAG_PT, a0);
        issue(1'b0, 19'h00011, '0, TAG_LPF, a1);
        issue(1'b0, 19'h00012, '0, TAG_VGA, a2);
        step(8);
        check("r3_rsp_count", rsp_q.size(), 3);
        check("r3_ce_cycles", ce_cnt, 3);
        check("r3_accepts_adjacent", a2 - a0, 2);
        if (rsp_q.size() == 3) begin
            check("r3_first_cycle", rsp_q[0].cyc - a0, 4);
            check("r3_last_cycle", rsp_q[2].cyc - a0, 6);
            check("r3_tag0", rsp_q[0].tag, 4'h8);
            check("r3_tag1", rsp_q[1].tag, 4'h4);
            check("r3_tag2", rsp_q[2].tag, 4'h2);
        end

        // Four back-to-back writes, then read one back
        clear_log();
        issue(1'b1, 19'h00020, 36'h1, TAG_NONE, a0);
        issue(1'b1, 19'h00021, 36'h2, TAG_NONE, a1);
        issue(1'b1, 19'h00022, 36'h3, TAG_NONE, a1);
        issue(1'b1, 19'h00023, 36'h4, TAG_NONE, a1);
        step(8);
        check("w4_we_cycles", we_cnt, 4);
        check("w4_bwe", bwe_bad_cnt, 0);
        check("w4_drive_count", drv_q.size(), 4);
        if (drv_q.size() == 4) begin
            check("w4_first_drive", drv_q[0].cyc - a0, 3);
            check("w4_last_drive", drv_q[3].cyc - a0, 6);
            check("w4_data0", drv_q[0].data, 36'h1);
            check("w4_data3", drv_q[3].data, 36'h4);
        end
        issue(1'b0, 19'h00022, '0, TAG_NTSC, ar);
        step(8);

        // Read followed by write: turnaround behaviour
        clear_log();
        issue(1'b0, 19'h00030, '0, TAG_VGA, ar);
        issue(1'b1, 19'h00031, 36'h987654321, TAG_NONE, aw);
        step(6);
        check("rw_stall_cycles", stall_cnt, EXP_STALL);
        check("rw_accept_gap", aw - ar, 1 + EXP_STALL);
        issue(1'b0, 19'h00031, '0, TAG_NTSC, ar);
        step(8);
        check("rw_contention", contention_cnt, 0);

        // Reset one cycle after two accepted reads
        clear_log();
        issue(1'b0, 19'h00020, '0, TAG_PT, a1);
        issue(1'b0, 19'h00021, '0, TAG_LPF, a2);
        reset = 1'b1;
        clear_ref();
        @(negedge clock);
        check("mid_rst_ready0", bus.req_ready, 1'b0);
        step(1);
        @(negedge clock);
        check("mid_rst_ready1", bus.req_ready, 1'b0);
        step(1);
        reset = 1'b0;
        @(negedge clock);
        check("post_rst_ready0", bus.req_ready, 1'b0);
        @(negedge clock);
        check("post_rst_ready1", bus.req_ready, 1'b1);
        step(8);
        check("mid_rst_no_rsp", rsp_q.size(), 0);
        check("mid_rst_no_drive", drv_q.size(), 0);
        check("mid_rst_no_oe", oe_cnt, 0);
        exp_q.delete();

        // Random mixed traffic checked by the scoreboard
        n_ops = 200;
        for (int i = 0; i < n_ops; i++) begin
            wr = 1'($urandom_range(0, 1));
            a  = 19'(32'h40 + $urandom_range(0, 7));
            d  = {4'($urandom_range(0, 15)), 32'($urandom)};
            t  = wr ? 4'h0 : 4'(1 << $urandom_range(0, 3));
            issue(wr, a, d, t, a0);
            if ($urandom_range(0, 3) == 0) step(1);
        end
        step(10);
        check("rand_drained", exp_q.size(), 0);
        check("rand_contention", contention_cnt, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
